uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
- Control stage between uart_rx and the ALU inside top_uart; also feeds uart_tx.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives the ALU inputs, captures the ALU result, hands it to uart_tx as one byte, then waits for TX completion.
- Has an inter-byte timeout and reports bytes dropped while busy.

Parameters:
- NB_DATA, 8: data/operand/result width; equals the UART byte width.
- NB_OP, 6: opcode width; opcode is taken from the low NB_OP bits of the third byte.
- TIMEOUT_CYC, 1000000: clk cycles allowed between consecutive bytes of a frame (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_rx_data  in  NB_DATA  byte from uart_rx; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe from uart_rx, byte available.
- i_alu_result  in  NB_DATA  combinational ALU result.
- i_tx_done  in  1  one-cycle strobe from uart_tx, byte fully shifted out.
- o_alu_a  out  NB_DATA  operand A register.
- o_alu_b  out  NB_DATA  operand B register.
- o_alu_op  out  NB_OP  opcode register.
- o_tx_data  out  NB_DATA  result byte for uart_tx.
- o_tx_start  out  1  one-cycle strobe, start transmission.
- o_busy  out  1  high in EXEC, SEND and WAIT_TX.
- o_timeout  out  1  one-cycle strobe, frame aborted by timeout.
- o_overrun  out  1  one-cycle strobe, byte dropped while busy.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE; all outputs 0; timeout counter 0. Reset mid-frame or mid-TX aborts with no strobe.
- States: IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- IDLE: on i_rx_done, o_alu_a<=i_rx_data, go to WAIT_B, clear counter.
- WAIT_B: on i_rx_done, o_alu_b<=i_rx_data, go to WAIT_OP, clear counter.
- WAIT_OP: on i_rx_done, o_alu_op<=i_rx_data[NB_OP-1:0] (upper bits ignored), go to EXEC.
- EXEC: one cycle so the ALU settles on the new registers; then go to SEND.
- SEND: o_tx_data<=i_alu_result, o_tx_start=1 for exactly this cycle, go to WAIT_TX.
- Latency: opcode strobe at cycle N -> o_alu_op valid at N+1 -> o_tx_start high at N+2 with o_tx_data valid the same cycle.
- WAIT_TX: hold o_tx_data; on i_tx_done go to IDLE. No timeout in this state.
- Timeout in WAIT_B/WAIT_OP: counter increments every cycle without i_rx_done.
  - When counter reaches TIMEOUT_CYC-1 without a byte: pulse o_timeout, go to IDLE, clear counter.
  - o_alu_a/o_alu_b keep their last values.
  - If i_rx_done arrives on the terminal count cycle, the byte wins and no timeout occurs.
- Overrun: i_rx_done in EXEC, SEND or WAIT_TX drops the byte, pulses o_overrun next cycle, leaves state unchanged.
- o_alu_a, o_alu_b, o_alu_op, o_tx_data hold until overwritten; they are never cleared except by reset.
- i_tx_done outside WAIT_TX is ignored.
- Counter width is ceil(log2(TIMEOUT_CYC)); it must not wrap.

Test Plan:
- Reset then bytes 0x05, 0x03, 0x20 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'h20; o_tx_start exactly 2 cycles after third strobe with o_tx_data = bench ALU model (ADD) = 0x08; after i_tx_done, o_busy=0 and state IDLE.
- Opcode byte 0xE2 -> o_alu_op=6'h22 (upper bits dropped); SUB 0x05-0x03 -> o_tx_data=0x02.
- TIMEOUT_CYC=16, send 0x11 then idle -> o_timeout pulses after 16 cycles; next bytes 0x01, 0x02, 0x20 are taken as a fresh A/B/op -> o_tx_data=0x03.
- Byte strobed during WAIT_TX -> o_overrun pulses once, o_alu_a unchanged, next full frame processed correctly.
- i_rst driven low asynchronously mid-WAIT_OP and mid-WAIT_TX -> all outputs 0 immediately, no o_tx_start, no o_timeout; normal frame works afterwards.
- Byte strobe coincides with the timeout terminal cycle -> byte accepted, no o_timeout.

Source files
------------

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: sequences UART bytes into ALU operands, returns the
// ALU result through the UART transmitter, guards frames with a timeout.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for operand A byte
// WAIT_B  | A captured, waiting for operand B byte (timeout armed)
// WAIT_OP | B captured, waiting for opcode byte (timeout armed)
// EXEC    | opcode captured, ALU settles on new operands for one cycle
// SEND    | result latched into o_tx_data, o_tx_start high this cycle
// WAIT_TX | result held until uart_tx reports the byte is out
module uart_alu_interface #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    // A single-cycle timeout still needs one counter bit.
    localparam int NB_CNT = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [NB_CNT-1:0] CNT_TERM = NB_CNT'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t             state_q;
    logic [NB_DATA-1:0] alu_a_q;
    logic [NB_DATA-1:0] alu_b_q;
    logic [NB_OP-1:0]   alu_op_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               timeout_q;
    logic               overrun_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               cnt_term;

    // The counter is cleared on every accepted byte and on timeout, so it
    // never runs past the terminal value.
    assign cnt_term = (cnt_q == CNT_TERM);

    // Frame sequencer: state, operand/result registers and output strobes.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_rx_done) begin
                        alu_a_q <= i_rx_data;
                        cnt_q   <= '0;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A byte on the terminal cycle takes priority over timeout.
                    if (i_rx_done) begin
                        alu_b_q <= i_rx_data;
                        cnt_q   <= '0;
                        state_q <= WAIT_OP;
                    end else if (cnt_term) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + NB_CNT'(1);
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        alu_op_q <= i_rx_data[NB_OP-1:0];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end else if (cnt_term) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + NB_CNT'(1);
                    end
                end
                EXEC: begin
                    // The ALU has seen the new operands for a full cycle, so
                    // its result is sampled here and presented during SEND.
                    overrun_q  <= i_rx_done;
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    overrun_q <= i_rx_done;
                    state_q   <= WAIT_TX;
                end
                WAIT_TX: begin
                    overrun_q <= i_rx_done;
                    if (i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a small ADD/SUB ALU model.
module tb_uart_alu_interface;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TO_CYC  = 16;

    logic               clk;
    logic               i_rst;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_to     = 0;
    int n_ov     = 0;

    uart_alu_interface #(
        .NB_DATA    (NB_DATA),
        .NB_OP      (NB_OP),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_overrun   (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU: 0x20 = ADD, 0x22 = SUB, anything else yields 0.
    always_comb begin
        i_alu_result = '0;
        if (o_alu_op == 6'h20) i_alu_result = o_alu_a + o_alu_b;
        else if (o_alu_op == 6'h22) i_alu_result = o_alu_a - o_alu_b;
    end

    // Strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (o_tx_start) n_start++;
        if (o_timeout)  n_to++;
        if (o_overrun)  n_ov++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte is sampled on the posedge between the two negedges; returns
    // on the negedge right after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    // Sends a whole frame and checks the two-cycle result latency.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        chk({tag, "_a"},      32'(o_alu_a), 32'(a));
        chk({tag, "_b"},      32'(o_alu_b), 32'(b));
        chk({tag, "_op"},     32'(o_alu_op), 32'(op[5:0]));
        chk({tag, "_exec"},   {o_busy, o_tx_start}, 32'b10);
        @(negedge clk);
        chk({tag, "_start"},  32'(o_tx_start), 32'd1);
        chk({tag, "_data"},   32'(o_tx_data), 32'(exp));
        @(negedge clk);
        chk({tag, "_start1"}, {o_busy, o_tx_start}, 32'b10);
        repeat (2) @(negedge clk);
        chk({tag, "_hold"},   32'(o_tx_data), 32'(exp));
        pulse_tx_done();
        chk({tag, "_idle"},   32'(o_busy), 32'd0);
    endtask

    initial begin
        int k;
        int first_to;
        i_rst     = 1'b0;
        i_rx_data = '0;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {o_alu_a, o_alu_b, 2'b00, o_alu_op, o_tx_data}, 32'h0);
        chk("rst_strb", {o_tx_start, o_busy, o_timeout, o_overrun}, 32'h0);
        i_rst = 1'b1;

        // ADD frame and opcode upper-bit stripping with SUB.
        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        run_frame("sub", 8'h05, 8'h03, 8'hE2, 8'h02);
        chk("start_cnt", 32'(n_start), 32'd2);

        // Inter-byte timeout after operand A.
        send_byte(8'h11);
        first_to = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (o_timeout && first_to == 0) first_to = i;
        end
        chk("to_cycle", 32'(first_to), 32'(TO_CYC));
        chk("to_count", 32'(n_to), 32'd1);
        chk("to_keep_a", 32'(o_alu_a), 32'h11);
        run_frame("post_to", 8'h01, 8'h02, 8'h20, 8'h03);

        // Byte arriving exactly on the terminal cycle is accepted.
        send_byte(8'h40);
        k = TO_CYC - 2;
        repeat (k) @(negedge clk);
        send_byte(8'h41);
        chk("term_b", 32'(o_alu_b), 32'h41);
        chk("term_noto", 32'(n_to), 32'd1);
        send_byte(8'h20);
        @(negedge clk);
        chk("term_start", 32'(o_tx_start), 32'd1);
        chk("term_data", 32'(o_tx_data), 32'h81);
        pulse_tx_done();
        chk("term_idle", 32'(o_busy), 32'd0);

        // Overrun while waiting for TX completion; stray tx_done in WAIT_B.
        send_byte(8'h0A);
        pulse_tx_done();
        send_byte(8'h0B);
        send_byte(8'h20);
        repeat (3) @(negedge clk);
        chk("ov_data", 32'(o_tx_data), 32'h15);
        send_byte(8'h77);
        chk("ov_pulse", 32'(o_overrun), 32'd1);
        chk("ov_keep_a", 32'(o_alu_a), 32'h0A);
        @(negedge clk);
        chk("ov_once", {o_overrun, o_busy}, 32'b01);
        chk("ov_count", 32'(n_ov), 32'd1);
        pulse_tx_done();
        run_frame("post_ov", 8'h09, 8'h04, 8'h22, 8'h05);

        // Asynchronous reset in WAIT_OP.
        send_byte(8'h33);
        send_byte(8'h44);
        k = n_start;
        #2 i_rst = 1'b0;
        #1;
        chk("arst1_ab", {o_alu_a, o_alu_b}, 32'h0);
        chk("arst1_st", {o_busy, o_tx_start, o_timeout, o_overrun}, 32'h0);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        repeat (TO_CYC + 4) @(negedge clk);
        chk("arst1_nostrb", n_to * 256 + (n_start - k), 32'd256);

        // Asynchronous reset in WAIT_TX.
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h20);
        repeat (3) @(negedge clk);
        chk("pre_arst2", {o_busy, o_tx_data}, 32'h10D);
        #2 i_rst = 1'b0;
        #1;
        chk("arst2_outs", {o_alu_a, o_alu_b, 2'b00, o_alu_op, o_tx_data}, 32'h0);
        chk("arst2_busy", 32'(o_busy), 32'd0);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        run_frame("post_rst", 8'h02, 8'h02, 8'h20, 8'h04);
        chk("final_to", 32'(n_to), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
